// File: rtl/blockram_access_arbiter.sv
// ----------------------------------------------------------------------------
// blockram_access_arbiter
//
// Shares one dual-port blockram among NUM_REQUESTER clients. Writes and reads
// are arbitrated independently, each by its own round-robin pointer, so one
// write and one read can be granted in the same cycle (on different clients).
// The owner of each granted read is remembered for one cycle so the blockram's
// registered read data can be steered back to the right client.
//
// Ports (N clients, W entry bits, A address bits, M mask bits; client i owns
// slice i of every flattened request bus):
//   clk_in, reset_in                 clock, synchronous active-high reset
//   request_valid_in/_write_in [N]   pending request, 1 = write / 0 = read
//   request_addr_in       [N*A]      set address
//   request_write_en_in   [N*M]      byte write mask
//   request_data_in       [N*W]      write data
//   request_ack_out       [N]        same-cycle grant (write grant | read grant)
//   response_valid_out    [N]        one-hot owner of the read data this cycle
//   response_data_out     [W]        read data (from blockram, unregistered)
//   response_hit_out                 blockram read valid, passed through
//   write_port_*_out                 blockram write port
//   read_port_*_out / read_port_*_in blockram read port
// ----------------------------------------------------------------------------
module blockram_access_arbiter #(
    parameter int NUM_REQUESTER              = 4,
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
    parameter int NUM_SET                    = 64,
    parameter int SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
    parameter int BYTE_LEN_IN_BITS           = 8,
    parameter int WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / BYTE_LEN_IN_BITS
) (
    input  logic                                                clk_in,
    input  logic                                                reset_in,
    input  logic [NUM_REQUESTER-1:0]                            request_valid_in,
    input  logic [NUM_REQUESTER-1:0]                            request_write_in,
    input  logic [NUM_REQUESTER*SET_PTR_WIDTH_IN_BITS-1:0]      request_addr_in,
    input  logic [NUM_REQUESTER*WRITE_MASK_LEN-1:0]             request_write_en_in,
    input  logic [NUM_REQUESTER*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_data_in,
    output logic [NUM_REQUESTER-1:0]                            request_ack_out,
    output logic [NUM_REQUESTER-1:0]                            response_valid_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]               response_data_out,
    output logic                                                response_hit_out,
    output logic                                                write_port_access_en_out,
    output logic [WRITE_MASK_LEN-1:0]                           write_port_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]                    write_port_access_set_addr_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]               write_port_data_out,
    output logic                                                read_port_access_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]                    read_port_access_set_addr_out,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]               read_port_data_in,
    input  logic                                                read_port_valid_in
);

    localparam int N     = NUM_REQUESTER;
    localparam int W     = SINGLE_ENTRY_WIDTH_IN_BITS;
    localparam int A     = SET_PTR_WIDTH_IN_BITS;
    localparam int M     = WRITE_MASK_LEN;
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    // Per-client views of the flattened request buses.
    logic [N-1:0][A-1:0] req_addr;
    logic [N-1:0][M-1:0] req_mask;
    logic [N-1:0][W-1:0] req_data;

    assign req_addr = request_addr_in;
    assign req_mask = request_write_en_in;
    assign req_data = request_data_in;

    // Returns {found, index} of the first set candidate at or after ptr,
    // wrapping past N-1. Scanning from the far end lets the closest
    // candidate overwrite the result last, so no early exit is needed.
    function automatic logic [PTR_W:0] rr_select(input logic [N-1:0]     cand,
                                                 input logic [PTR_W-1:0] ptr);
        logic [PTR_W:0] res;
        int             idx;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (cand[PTR_W'(idx)]) res = {1'b1, PTR_W'(idx)};
        end
        return res;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] idx);
        return (int'(idx) == N - 1) ? '0 : idx + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             resp_pending_q, resp_pending_d;
    logic [N-1:0]     resp_owner_q, resp_owner_d;

    // ------------------------------------------------------------------
    // Arbitration (combinational, zero-cycle ack)
    // ------------------------------------------------------------------
    logic [N-1:0]     wr_cand, rd_cand;
    logic [PTR_W:0]   wr_sel, rd_sel;
    logic             wr_gnt_vld, rd_gnt_vld;
    logic [PTR_W-1:0] wr_idx, rd_idx;
    logic [N-1:0]     wr_gnt, rd_gnt;

    assign wr_cand = request_valid_in & request_write_in;
    assign rd_cand = request_valid_in & ~request_write_in;

    assign wr_sel = rr_select(wr_cand, wr_ptr_q);
    assign rd_sel = rr_select(rd_cand, rd_ptr_q);

    // Grants are suppressed while reset is held so nothing reaches the RAM.
    assign wr_gnt_vld = wr_sel[PTR_W] & ~reset_in;
    assign rd_gnt_vld = rd_sel[PTR_W] & ~reset_in;
    assign wr_idx     = wr_sel[PTR_W-1:0];
    assign rd_idx     = rd_sel[PTR_W-1:0];

    assign wr_gnt = wr_gnt_vld ? (N'(1) << wr_idx) : '0;
    assign rd_gnt = rd_gnt_vld ? (N'(1) << rd_idx) : '0;

    assign request_ack_out = wr_gnt | rd_gnt;

    // ------------------------------------------------------------------
    // Blockram ports, driven straight from the granted slice
    // ------------------------------------------------------------------
    assign write_port_access_en_out       = wr_gnt_vld;
    assign write_port_write_en_out        = wr_gnt_vld ? req_mask[wr_idx] : '0;
    assign write_port_access_set_addr_out = wr_gnt_vld ? req_addr[wr_idx] : '0;
    assign write_port_data_out            = wr_gnt_vld ? req_data[wr_idx] : '0;

    assign read_port_access_en_out        = rd_gnt_vld;
    assign read_port_access_set_addr_out  = rd_gnt_vld ? req_addr[rd_idx] : '0;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d       = wr_gnt_vld ? ptr_inc(wr_idx) : wr_ptr_q;
        rd_ptr_d       = rd_gnt_vld ? ptr_inc(rd_idx) : rd_ptr_q;
        resp_pending_d = rd_gnt_vld;
        // Owner only matters while pending; keep it otherwise.
        resp_owner_d   = rd_gnt_vld ? rd_gnt : resp_owner_q;
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            resp_pending_q <= 1'b0;
            resp_owner_q   <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            resp_pending_q <= resp_pending_d;
            resp_owner_q   <= resp_owner_d;
        end
    end

    // ------------------------------------------------------------------
    // Response: RAM output is already one cycle behind the read grant,
    // so data and hit pass through; only the owner is registered.
    // ------------------------------------------------------------------
    assign response_valid_out = (resp_pending_q && !reset_in) ? resp_owner_q : '0;
    assign response_data_out  = read_port_data_in;
    assign response_hit_out   = read_port_valid_in;

endmodule

// File: tb/tb_blockram_access_arbiter.sv
module tb_blockram_access_arbiter;
    localparam int N = 4;
    localparam int W = 64;
    localparam int S = 64;
    localparam int A = 6;
    localparam int M = 8;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]        vld, wr;
    logic [N-1:0][A-1:0] addr;
    logic [N-1:0][M-1:0] mask;
    logic [N-1:0][W-1:0] data;

    logic [N-1:0] ack, rv;
    logic [W-1:0] rdata;
    logic         hit;
    logic         wpe, rpe;
    logic [M-1:0] wpm;
    logic [A-1:0] wpa, rpa;
    logic [W-1:0] wpd;
    logic [W-1:0] bram_q;
    logic         bram_v;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    blockram_access_arbiter #(
        .NUM_REQUESTER(N), .SINGLE_ENTRY_WIDTH_IN_BITS(W), .NUM_SET(S)
    ) dut (
        .clk_in                         (clk),
        .reset_in                       (rst),
        .request_valid_in               (vld),
        .request_write_in               (wr),
        .request_addr_in                (addr),
        .request_write_en_in            (mask),
        .request_data_in                (data),
        .request_ack_out                (ack),
        .response_valid_out             (rv),
        .response_data_out              (rdata),
        .response_hit_out               (hit),
        .write_port_access_en_out       (wpe),
        .write_port_write_en_out        (wpm),
        .write_port_access_set_addr_out (wpa),
        .write_port_data_out            (wpd),
        .read_port_access_en_out        (rpe),
        .read_port_access_set_addr_out  (rpa),
        .read_port_data_in              (bram_q),
        .read_port_valid_in             (bram_v)
    );

    // Blockram stand-in (ReadFirst): registered read, byte-masked write,
    // valid = entry has been written at least once.
    logic [W-1:0] mem [S] = '{default: '0};
    logic [S-1:0] mem_v   = '0;

    always @(posedge clk) begin
        if (rpe) begin
            bram_q <= mem[rpa];
            bram_v <= mem_v[rpa];
        end
        if (wpe) begin
            for (int b = 0; b < M; b++)
                if (wpm[b]) mem[wpa][b*8 +: 8] <= wpd[b*8 +: 8];
            mem_v[wpa] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Reference model: round-robin by index arithmetic, shadow memory.
    // ------------------------------------------------------------------
    int           m_wptr, m_rptr, m_owner;
    bit           m_pend;
    logic [W-1:0] m_rdata;
    bit           m_rhit;
    logic [W-1:0] m_mem [S];
    bit           m_memv [S];

    function automatic int rr(input logic [N-1:0] cand, input int ptr);
        for (int k = 0; k < N; k++)
            if (cand[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        int wg, rg;
        logic [N-1:0] e_ack, e_rv;
        wg = rst ? -1 : rr(vld & wr, m_wptr);
        rg = rst ? -1 : rr(vld & ~wr, m_rptr);
        e_ack = '0;
        if (wg >= 0) e_ack[wg] = 1'b1;
        if (rg >= 0) e_ack[rg] = 1'b1;
        e_rv = '0;
        if (!rst && m_pend) e_rv[m_owner] = 1'b1;
        chk("m_ack",     64'(ack), 64'(e_ack));
        chk("m_wr_en",   64'(wpe), 64'(wg >= 0));
        chk("m_wr_addr", 64'(wpa), (wg >= 0) ? 64'(addr[wg]) : 64'd0);
        chk("m_wr_mask", 64'(wpm), (wg >= 0) ? 64'(mask[wg]) : 64'd0);
        chk("m_wr_data", wpd,      (wg >= 0) ? data[wg] : 64'd0);
        chk("m_rd_en",   64'(rpe), 64'(rg >= 0));
        chk("m_rd_addr", 64'(rpa), (rg >= 0) ? 64'(addr[rg]) : 64'd0);
        chk("m_resp_valid", 64'(rv), 64'(e_rv));
        if (!rst && m_pend) begin
            chk("m_resp_data", rdata, m_rdata);
            chk("m_resp_hit", 64'(hit), 64'(m_rhit));
        end
    endtask

    task automatic model_update();
        int wg, rg;
        if (rst) begin
            m_wptr = 0; m_rptr = 0; m_pend = 1'b0;
        end else begin
            wg = rr(vld & wr, m_wptr);
            rg = rr(vld & ~wr, m_rptr);
            if (rg >= 0) begin
                m_pend  = 1'b1;
                m_owner = rg;
                m_rdata = m_mem[addr[rg]];
                m_rhit  = m_memv[addr[rg]];
                m_rptr  = (rg + 1) % N;
            end else begin
                m_pend = 1'b0;
            end
            if (wg >= 0) begin
                for (int b = 0; b < M; b++)
                    if (mask[wg][b]) m_mem[addr[wg]][b*8 +: 8] = data[wg][b*8 +: 8];
                m_memv[addr[wg]] = 1'b1;
                m_wptr = (wg + 1) % N;
            end
        end
    endtask

    // One clock cycle: inputs already set after a falling edge.
    task automatic step();
        #1;
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; vld = '1; wr = 4'b0101;
        #1;
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_rv",  64'(rv),  64'd0);
        chk("rst_en",  64'({wpe, rpe}), 64'd0);
        step();
        rst = 1'b0; vld = '0; wr = '0;
    endtask

    typedef struct packed {
        logic [N-1:0] vld, wr, ack;
        logic         wen;
        logic [A-1:0] waddr;
        logic         ren;
        logic [A-1:0] raddr;
        logic [N-1:0] rv;
    } vec_t;

    vec_t tv [8];

    initial begin
        for (int i = 0; i < S; i++) begin m_mem[i] = '0; m_memv[i] = 1'b0; end
        m_wptr = 0; m_rptr = 0; m_owner = 0; m_pend = 1'b0; m_rdata = '0; m_rhit = 1'b0;
        rst = 1'b1; vld = '0; wr = '0; addr = '0; mask = '0; data = '0;

        //            vld      wr       ack      wen   waddr  ren   raddr  rv
        tv[0] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 6'd0,  1'b0, 6'd0,  4'b0000};
        tv[1] = '{4'b1111, 4'b1111, 4'b0001, 1'b1, 6'd10, 1'b0, 6'd0,  4'b0000};
        tv[2] = '{4'b1111, 4'b1111, 4'b0010, 1'b1, 6'd11, 1'b0, 6'd0,  4'b0000};
        tv[3] = '{4'b1111, 4'b0101, 4'b0110, 1'b1, 6'd12, 1'b1, 6'd11, 4'b0000};
        tv[4] = '{4'b1111, 4'b0101, 4'b1001, 1'b1, 6'd10, 1'b1, 6'd13, 4'b0010};
        tv[5] = '{4'b1000, 4'b0000, 4'b1000, 1'b0, 6'd0,  1'b1, 6'd13, 4'b1000};
        tv[6] = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 6'd10, 1'b0, 6'd0,  4'b1000};
        tv[7] = '{4'b0110, 4'b0000, 4'b0010, 1'b0, 6'd0,  1'b1, 6'd11, 4'b0000};

        @(negedge clk);
        do_reset();

        // ---- Table-driven vectors from reset pointers ----
        for (int c = 0; c < N; c++) begin
            addr[c] = A'(10 + c);
            mask[c] = '1;
            data[c] = {8{8'(8'hA0 + c)}};
        end
        for (int i = 0; i < 8; i++) begin
            vld = tv[i].vld; wr = tv[i].wr;
            #1;
            chk("tbl_ack",   64'(ack), 64'(tv[i].ack));
            chk("tbl_wen",   64'(wpe), 64'(tv[i].wen));
            chk("tbl_waddr", 64'(wpa), 64'(tv[i].waddr));
            chk("tbl_ren",   64'(rpe), 64'(tv[i].ren));
            chk("tbl_raddr", 64'(rpa), 64'(tv[i].raddr));
            chk("tbl_rv",    64'(rv),  64'(tv[i].rv));
            step();
        end

        // ---- Masked write then read of addr 63 by client 0 ----
        do_reset();
        addr[0] = 6'd63; mask[0] = 8'h55; data[0] = '1;
        vld = 4'b0001; wr = 4'b0001;
        #1;
        chk("A_wr_ack", 64'(ack), 64'h1);
        chk("A_wr_addr", 64'(wpa), 64'd63);
        chk("A_wr_mask", 64'(wpm), 64'h55);
        step();
        wr = 4'b0000;
        #1;
        chk("A_rd_ack", 64'(ack), 64'h1);
        chk("A_rd_addr", 64'(rpa), 64'd63);
        step();
        vld = '0;
        #1;
        chk("A_rv", 64'(rv), 64'h1);
        chk("A_data", rdata, 64'h00ff00ff00ff00ff);
        chk("A_hit", 64'(hit), 64'h1);
        step();

        // ---- Read of never-written addr 1 by client 2 ----
        addr[2] = 6'd1; vld = 4'b0100; wr = '0;
        #1;
        chk("B_ack", 64'(ack), 64'h4);
        step();
        vld = '0;
        #1;
        chk("B_rv", 64'(rv), 64'h4);
        chk("B_hit", 64'(hit), 64'h0);
        step();

        // ---- All clients reading continuously from reset ----
        do_reset();
        vld = '1; wr = '0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("C_ack", 64'(ack), 64'(1) << (i % N));
            if (i > 0) chk("C_rv", 64'(rv), 64'(1) << ((i - 1) % N));
            step();
        end
        vld = '0;

        // ---- Same-cycle write (client 1, addr 1) and read (client 3, addr 63) ----
        do_reset();
        addr[1] = 6'd1; mask[1] = '1; data[1] = {8{8'hf0}}; addr[3] = 6'd63;
        vld = 4'b1010; wr = 4'b0010;
        #1;
        chk("D_ack", 64'(ack), 64'ha);
        chk("D_waddr", 64'(wpa), 64'd1);
        chk("D_raddr", 64'(rpa), 64'd63);
        step();
        addr[0] = 6'd1; vld = 4'b0001; wr = '0;
        #1;
        chk("D_rv3", 64'(rv), 64'h8);
        chk("D_data63", rdata, 64'h00ff00ff00ff00ff);
        chk("D_ack0", 64'(ack), 64'h1);
        step();
        vld = '0;
        #1;
        chk("D_rv0", 64'(rv), 64'h1);
        chk("D_data1", rdata, {8{8'hf0}});
        chk("D_hit1", 64'(hit), 64'h1);
        step();

        // ---- Read pointer at 1 with clients 0 and 2 requesting ----
        do_reset();
        vld = 4'b0001; wr = '0;
        step();
        vld = 4'b0101;
        #1; chk("E_first", 64'(ack), 64'h4);
        step();
        vld = 4'b0001;
        #1; chk("E_second", 64'(ack), 64'h1);
        step();
        vld = 4'b1111;
        #1; chk("E_ptr1", 64'(ack), 64'h2);
        step();
        vld = '0;

        // ---- Reset right after a read ack ----
        do_reset();
        vld = 4'b0011; wr = 4'b0010;
        #1; chk("F_ack", 64'(ack), 64'h3);
        step();
        rst = 1'b1; vld = '1; wr = '0;
        #1;
        chk("F_rst_ack", 64'(ack), 64'h0);
        chk("F_rst_rv", 64'(rv), 64'h0);
        chk("F_rst_ren", 64'(rpe), 64'h0);
        step();
        rst = 1'b0; vld = '0;
        #1; chk("F_rv_after", 64'(rv), 64'h0);
        step();
        vld = 4'b1111; wr = 4'b1010;
        #1; chk("F_ptrs0", 64'(ack), 64'h3);
        step();
        vld = '0;

        // ---- Randomized traffic against the model ----
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            vld = N'($urandom);
            wr  = N'($urandom);
            for (int c = 0; c < N; c++) begin
                addr[c] = A'($urandom_range(0, 15));
                mask[c] = M'($urandom);
                data[c] = {$urandom, $urandom};
            end
            step();
        end
        rst = 1'b0; vld = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
